// File: rtl/be_core.sv
// be_core: parametrised accumulator CPU core with one synchronous
// memory bus and a ready wait handshake.
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   rst     in   synchronous active-high reset
//   ready   in   bus access completes on an edge where ready=1
//   rdata   in   [DW] read data, sampled at the completing edge
//   addr    out  [AW] bus address
//   wdata   out  [DW] write data (always the A register)
//   we      out  write strobe, high only in STORE
//   halted  out  high while in HALT
//   acc     out  [DW] A register
//   carry   out  C flag
module be_core #(
    parameter int DW = 8,
    parameter int AW = 8,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b1}} - AW'(15)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ready,
    input  logic [DW-1:0] rdata,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    output logic          we,
    output logic          halted,
    output logic [DW-1:0] acc,
    output logic          carry
);

    generate
        if (AW > DW || DW < 4 || DW > 32) begin : g_bad_params
            $error("be_core: need 4 <= DW <= 32 and AW <= DW");
        end
    endgenerate

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_OPER   = 3'd2;
    localparam logic [2:0] S_LOAD   = 3'd3;
    localparam logic [2:0] S_STORE  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SWP = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_JC  = 4'h9;
    localparam logic [3:0] OP_CLC = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hB;

    logic [2:0]    state;
    logic [AW-1:0] pc;
    logic [AW-1:0] ar;
    logic [DW-1:0] ir;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          c;

    logic [3:0]    op;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] opnd;
    logic [DW:0]   sum;
    logic [DW:0]   dif;

    logic [DW-1:0] a_nx;
    logic [DW-1:0] b_nx;
    logic          c_nx;
    logic [2:0]    dec_nx;
    logic          take;
    logic [2:0]    oper_nx;

    // Only the low nibble of IR selects the operation.
    logic unused_ir;
    assign unused_ir = ^ir[DW-1:4];

    assign op     = ir[3:0];
    assign pc_inc = pc + AW'(1);
    assign opnd   = rdata[AW-1:0];

    // Both computed at DW+1 bits; the top bit is carry or borrow.
    assign sum = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
    assign dif = {1'b0, a} - {1'b0, b} - {{DW{1'b0}}, c};

    always_comb begin
        a_nx   = a;
        b_nx   = b;
        c_nx   = c;
        dec_nx = S_FETCH;
        unique case (1'b1)
            op == OP_ADD: begin
                a_nx = sum[DW-1:0];
                c_nx = sum[DW];
            end
            op == OP_SWP: begin
                a_nx = b;
                b_nx = a;
            end
            op == OP_SUB: begin
                a_nx = dif[DW-1:0];
                c_nx = dif[DW];
            end
            op == OP_AND: begin
                a_nx = a & b;
                c_nx = 1'b0;
            end
            op == OP_OR: begin
                a_nx = a | b;
                c_nx = 1'b0;
            end
            op == OP_XOR: begin
                a_nx = a ^ b;
                c_nx = 1'b0;
            end
            op == OP_CLC: c_nx = 1'b0;
            op == OP_HLT: dec_nx = S_HALT;
            op == OP_LDA,
            op == OP_STA,
            op == OP_JMP,
            op == OP_JC:  dec_nx = S_OPER;
            default: ;
        endcase
    end

    always_comb begin
        take    = (op == OP_JMP) || (op == OP_JC && c);
        oper_nx = S_FETCH;
        if (op == OP_LDA) oper_nx = S_LOAD;
        if (op == OP_STA) oper_nx = S_STORE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            ar    <= '0;
            a     <= '0;
            b     <= '0;
            c     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (ready) begin
                        ir    <= rdata;
                        pc    <= pc_inc;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a     <= a_nx;
                    b     <= b_nx;
                    c     <= c_nx;
                    state <= dec_nx;
                end
                S_OPER: begin
                    if (ready) begin
                        ar    <= opnd;
                        pc    <= take ? opnd : pc_inc;
                        state <= oper_nx;
                    end
                end
                S_LOAD: begin
                    if (ready) begin
                        a     <= rdata;
                        state <= S_FETCH;
                    end
                end
                S_STORE: begin
                    if (ready) state <= S_FETCH;
                end
                S_HALT: ;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Bus outputs decode registered state only.
    assign addr   = (state == S_LOAD || state == S_STORE) ? ar : pc;
    assign we     = (state == S_STORE);
    assign wdata  = a;
    assign halted = (state == S_HALT);
    assign acc    = a;
    assign carry  = c;

endmodule

// File: tb/tb_be_core.sv
// tb_be_core: instruction-level reference model driving a memory with
// random wait states; bus activity is checked cycle by cycle.
module tb_be_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       ready;
    logic [7:0] rdata;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic       halted;
    logic [7:0] acc;
    logic       carry;

    be_core dut (
        .clk    (clk),
        .rst    (rst),
        .ready  (ready),
        .rdata  (rdata),
        .addr   (addr),
        .wdata  (wdata),
        .we     (we),
        .halted (halted),
        .acc    (acc),
        .carry  (carry)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One expected bus cycle: wt=1 means it only advances on ready.
    typedef struct {
        logic [7:0] addr;
        logic       we;
        logic [7:0] wd;
        bit         wt;
        bit         hlt;
        bit         fet;
        logic [7:0] a;
        logic       c;
    } ph_t;

    ph_t q[$];

    logic [7:0] mem  [256];
    logic [7:0] rmem [256];
    logic [7:0] m_pc;
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic       m_c;
    bit         m_halt;

    function automatic void push(input logic [7:0] ad, input logic w,
                                 input logic [7:0] wd, input bit wt,
                                 input bit hl, input bit fe);
        ph_t p;
        p.addr = ad;
        p.we   = w;
        p.wd   = wd;
        p.wt   = wt;
        p.hlt  = hl;
        p.fet  = fe;
        p.a    = m_a;
        p.c    = m_c;
        q.push_back(p);
    endfunction

    // Execute one instruction and queue the bus cycles it implies.
    function automatic void gen();
        logic [7:0] ir;
        logic [7:0] pc1;
        logic [7:0] opv;
        logic [7:0] t;
        int s;
        if (m_halt) begin
            push(m_pc, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            return;
        end
        ir  = rmem[m_pc];
        pc1 = m_pc + 8'd1;
        push(m_pc, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        push(pc1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        m_pc = pc1;
        case (ir[3:0])
            4'h0: begin
                s = int'(m_a) + int'(m_b) + int'(m_c);
                m_a = 8'(s);
                m_c = (s > 255);
            end
            4'h1: begin
                t = m_a; m_a = m_b; m_b = t;
            end
            4'h5: begin
                s = int'(m_a) - int'(m_b) - int'(m_c);
                m_a = 8'(s);
                m_c = (s < 0);
            end
            4'h6: begin m_a = m_a & m_b; m_c = 1'b0; end
            4'h7: begin m_a = m_a | m_b; m_c = 1'b0; end
            4'h8: begin m_a = m_a ^ m_b; m_c = 1'b0; end
            4'hA: m_c = 1'b0;
            4'hB: m_halt = 1'b1;
            4'h2, 4'h3, 4'h4, 4'h9: begin
                opv = rmem[pc1];
                push(pc1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
                m_pc = pc1 + 8'd1;
                if (ir[3:0] == 4'h4) m_pc = opv;
                if (ir[3:0] == 4'h9 && m_c) m_pc = opv;
                if (ir[3:0] == 4'h2) begin
                    push(opv, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
                    m_a = rmem[opv];
                end
                if (ir[3:0] == 4'h3)
                    push(opv, 1'b1, m_a, 1'b1, 1'b0, 1'b0);
            end
            default: ;
        endcase
    endfunction

    task automatic do_reset();
        rst   = 1'b1;
        ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_we", we, 1'b0);
        chk("rst_addr", addr, 8'hF0);
        chk("rst_acc", acc, 8'h00);
        chk("rst_carry", carry, 1'b0);
        chk("rst_halted", halted, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        m_pc   = 8'hF0;
        m_a    = 8'h00;
        m_b    = 8'h00;
        m_c    = 1'b0;
        m_halt = 1'b0;
        q.delete();
    endtask

    task automatic run(input int cycles, input int pct, input bit rst_st);
        ph_t p;
        logic [7:0] sa;
        logic [7:0] sw;
        logic swe;
        bit r;
        for (int n = 0; n < cycles; n++) begin
            if (q.size() == 0) gen();
            p = q[0];
            @(negedge clk);
            sa  = addr;
            swe = we;
            sw  = wdata;
            chk("addr", addr, p.addr);
            chk("we", we, p.we);
            chk("halted", halted, p.hlt);
            if (p.fet) begin
                chk("acc", acc, p.a);
                chk("carry", carry, p.c);
                chk("wdata", wdata, p.a);
            end
            if (p.we) chk("st_wdata", wdata, p.wd);
            if (bad != 0) return;
            if (rst_st && p.we) begin
                do_reset();
                return;
            end
            r = ($urandom_range(99) < pct);
            ready = r;
            rdata = mem[sa];
            @(posedge clk);
            if (swe && r) mem[sa] = sw;
            if (!p.wt || r) begin
                if (p.we) rmem[p.addr] = p.wd;
                void'(q.pop_front());
            end
        end
    endtask

    task automatic cmp_mem();
        for (int i = 0; i < 256; i++)
            if (mem[i] !== rmem[i])
                chk($sformatf("mem%0h", i), mem[i], rmem[i]);
        chk("mem80", mem[8'h80], rmem[8'h80]);
    endtask

    task automatic load_p1();
        logic [7:0] img [256];
        for (int i = 0; i < 256; i++) img[i] = 8'h0C;
        img[8'hF0] = 8'h02; img[8'hF1] = 8'h40;
        img[8'hF2] = 8'h01;
        img[8'hF3] = 8'h02; img[8'hF4] = 8'h41;
        img[8'hF5] = 8'h00;
        img[8'hF6] = 8'h00;
        img[8'hF7] = 8'h02; img[8'hF8] = 8'h43;
        img[8'hF9] = 8'h01;
        img[8'hFA] = 8'h02; img[8'hFB] = 8'h42;
        img[8'hFC] = 8'h05;
        img[8'hFD] = 8'h09; img[8'hFE] = 8'h20;
        img[8'hFF] = 8'h0C;
        img[8'h00] = 8'h0B;
        img[8'h20] = 8'h02; img[8'h21] = 8'h44;
        img[8'h22] = 8'h01;
        img[8'h23] = 8'h0A;
        img[8'h24] = 8'h05;
        img[8'h25] = 8'h09; img[8'h26] = 8'h30;
        img[8'h27] = 8'h02; img[8'h28] = 8'h45;
        img[8'h29] = 8'h03; img[8'h2A] = 8'h80;
        img[8'h2B] = 8'h04; img[8'h2C] = 8'hFF;
        img[8'h40] = 8'h01;
        img[8'h41] = 8'hFF;
        img[8'h42] = 8'h03;
        img[8'h43] = 8'h05;
        img[8'h44] = 8'h03;
        img[8'h45] = 8'h5A;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = img[i];
            rmem[i] = img[i];
        end
    endtask

    initial begin
        rst   = 1'b1;
        ready = 1'b0;
        rdata = 8'h00;
        load_p1();
        @(negedge clk);
        do_reset();

        run(90, 100, 1'b0);
        @(negedge clk);
        chk("halt_addr", addr, 8'h01);
        chk("halt_flag", halted, 1'b1);
        chk("sta_mem80", mem[8'h80], 8'h5A);
        do_reset();
        cmp_mem();

        load_p1();
        run(250, 50, 1'b0);
        @(negedge clk);
        do_reset();
        cmp_mem();

        load_p1();
        run(250, 60, 1'b1);
        @(negedge clk);
        do_reset();
        cmp_mem();
        chk("rst_nowrite80", mem[8'h80], 8'h0C);

        for (int k = 0; k < 25; k++) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]  = 8'($urandom);
                rmem[i] = mem[i];
            end
            run(300, 70, (k % 3) == 0);
            @(negedge clk);
            do_reset();
            cmp_mem();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
